// File: rtl/multiexp_g1_input_pair_if.sv
// Stream bundle for the multiexp G1 input pairer: scalar and point input streams plus the
// paired output stream. The slave modport is the pairer itself; master is its environment.
interface multiexp_g1_input_pair_if #(
    parameter int unsigned SCL_BITS = 256,
    parameter int unsigned PNT_BITS = 512
);
    logic                         s_scl_tvalid;
    logic                         s_scl_tready;
    logic [SCL_BITS-1:0]          s_scl_tdata;
    logic                         s_pnt_tvalid;
    logic                         s_pnt_tready;
    logic [PNT_BITS-1:0]          s_pnt_tdata;
    logic                         m_tvalid;
    logic                         m_tready;
    logic [SCL_BITS+PNT_BITS-1:0] m_tdata;
    logic                         m_tsop;
    logic                         m_teop;

    modport slave (
        input  s_scl_tvalid, s_scl_tdata, s_pnt_tvalid, s_pnt_tdata, m_tready,
        output s_scl_tready, s_pnt_tready, m_tvalid, m_tdata, m_tsop, m_teop
    );

    modport master (
        output s_scl_tvalid, s_scl_tdata, s_pnt_tvalid, s_pnt_tdata, m_tready,
        input  s_scl_tready, s_pnt_tready, m_tvalid, m_tdata, m_tsop, m_teop
    );
endinterface

// File: rtl/multiexp_g1_input_pair.sv
// Joins scalar and point streams into {point, scalar} beats for the multiexp core.
// Optional MULTIEXP_PAIR_ZERO_SKIP_EN drops zero-scalar pairs except the final one.
module multiexp_g1_input_pair #(
    parameter int unsigned SCL_BITS = 256,
    parameter int unsigned PNT_BITS = 512,
    parameter int unsigned CNT_BITS = 64
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  i_start,
    input  logic [CNT_BITS-1:0]   i_num_in,
    multiexp_g1_input_pair_if.slave bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_BITS-1:0]   o_cnt
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                       state_q, state_d;
    logic [CNT_BITS-1:0]          num_q, num_d;
    logic [CNT_BITS-1:0]          idx_q, idx_d;
    logic [CNT_BITS-1:0]          cnt_q, cnt_d;
    logic                         sop_pend_q, sop_pend_d;
    logic                         m_valid_q, m_valid_d;
    logic                         m_sop_q, m_sop_d;
    logic                         m_eop_q, m_eop_d;
    logic [SCL_BITS+PNT_BITS-1:0] m_data_q, m_data_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         m_hs, accept, last, emit;

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        sop_pend_d = sop_pend_q;
        m_valid_d  = m_valid_q;
        m_sop_d    = m_sop_q;
        m_eop_d    = m_eop_q;
        m_data_d   = m_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        m_hs   = m_valid_q & bus.m_tready;
        // A pair may enter the slot when it is empty or being drained this cycle.
        accept = (state_q == StRun) & bus.s_scl_tvalid & bus.s_pnt_tvalid
                 & (~m_valid_q | bus.m_tready);
        last   = (idx_q == num_q - CNT_BITS'(1));
`ifdef MULTIEXP_PAIR_ZERO_SKIP_EN
        emit   = (bus.s_scl_tdata != '0) | last;
`else
        emit   = 1'b1;
`endif

        if (m_hs) begin
            m_valid_d = 1'b0;
            cnt_d     = cnt_q + CNT_BITS'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    cnt_d = '0;
                    if (i_num_in != '0) begin
                        num_d      = i_num_in;
                        idx_d      = '0;
                        sop_pend_d = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = StRun;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    idx_d = idx_q + CNT_BITS'(1);
                    if (emit) begin
                        m_valid_d  = 1'b1;
                        m_data_d   = {bus.s_pnt_tdata, bus.s_scl_tdata};
                        m_sop_d    = sop_pend_q;
                        m_eop_d    = last;
                        sop_pend_d = 1'b0;
                    end
                    if (last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (m_hs && m_eop_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= StIdle;
            num_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            sop_pend_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_sop_q    <= 1'b0;
            m_eop_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            sop_pend_q <= sop_pend_d;
            m_valid_q  <= m_valid_d;
            m_sop_q    <= m_sop_d;
            m_eop_q    <= m_eop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Payload needs no reset; it is only meaningful while m_tvalid is high.
    always_ff @(posedge ap_clk) begin
        m_data_q <= m_data_d;
    end

    assign bus.s_scl_tready = accept;
    assign bus.s_pnt_tready = accept;
    assign bus.m_tvalid     = m_valid_q;
    assign bus.m_tdata      = m_data_q;
    assign bus.m_tsop       = m_sop_q;
    assign bus.m_teop       = m_eop_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_cnt            = cnt_q;
endmodule

// File: tb/tb_multiexp_g1_input_pair.sv
// Directed-plus-random bench for multiexp_g1_input_pair; expected beats come from a list model.
module tb_multiexp_g1_input_pair;
    localparam int unsigned SB = 32;
    localparam int unsigned PB = 64;
    localparam int unsigned CB = 16;
    localparam int unsigned W  = SB + PB;
`ifdef MULTIEXP_PAIR_ZERO_SKIP_EN
    localparam bit ZeroSkip = 1'b1;
`else
    localparam bit ZeroSkip = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         sop;
        logic         eop;
    } beat_t;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          i_start;
    logic [CB-1:0] i_num_in;
    logic          o_busy;
    logic          o_done;
    logic [CB-1:0] o_cnt;

    multiexp_g1_input_pair_if #(.SCL_BITS(SB), .PNT_BITS(PB)) bus ();

    multiexp_g1_input_pair #(.SCL_BITS(SB), .PNT_BITS(PB), .CNT_BITS(CB)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .i_start  (i_start),
        .i_num_in (i_num_in),
        .bus      (bus),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_cnt    (o_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    int cyc = 0;
    int scl_idx, pnt_idx;
    bit scl_on, pnt_on;
    int pnt_period, rdy_pct;
    logic [SB-1:0] scl_src[$];
    logic [PB-1:0] pnt_src[$];
    beat_t got[$];
    beat_t exp_q[$];
    int hs_cyc[$];
    int done_n, done_cyc;
    bit tready_bad, tready_seen;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        chk_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic prep(input int num);
        scl_src.delete();
        pnt_src.delete();
        for (int i = 0; i < num + 2; i++) begin
            scl_src.push_back($urandom);
            pnt_src.push_back({$urandom, $urandom});
        end
    endtask

    // One clock: observe registered outputs, drive inputs, record handshakes of the next edge.
    task automatic tick(input bit start, input int num);
        beat_t b;
        @(negedge ap_clk);
        cyc++;
        if (o_done) begin
            done_n++;
            done_cyc = cyc;
        end
        i_start  = start;
        i_num_in = CB'(num);
        bus.s_scl_tvalid = scl_on && (scl_idx < scl_src.size());
        bus.s_scl_tdata  = (scl_idx < scl_src.size()) ? scl_src[scl_idx] : '0;
        bus.s_pnt_tvalid = pnt_on && (pnt_idx < pnt_src.size()) && (cyc % pnt_period == 0);
        bus.s_pnt_tdata  = (pnt_idx < pnt_src.size()) ? pnt_src[pnt_idx] : '0;
        bus.m_tready     = ($urandom_range(99) < rdy_pct);
        #1;
        if (bus.s_scl_tready !== bus.s_pnt_tready) tready_bad = 1'b1;
        if (bus.s_scl_tready || bus.s_pnt_tready) tready_seen = 1'b1;
        if (bus.s_scl_tvalid && bus.s_scl_tready) scl_idx++;
        if (bus.s_pnt_tvalid && bus.s_pnt_tready) pnt_idx++;
        if (bus.m_tvalid && bus.m_tready) begin
            b.d   = bus.m_tdata;
            b.sop = bus.m_tsop;
            b.eop = bus.m_teop;
            got.push_back(b);
            hs_cyc.push_back(cyc);
        end
    endtask

    task automatic run_job(input string name, input int num, input int period, input int rdy,
                           input bit stray, input bit consec);
        beat_t b;
        bit first;
        int start_cyc, t, exp_done, n;
        exp_q.delete();
        first = 1'b1;
        for (int i = 0; i < num; i++) begin
            if (!ZeroSkip || scl_src[i] != '0 || i == num - 1) begin
                b.d   = {pnt_src[i], scl_src[i]};
                b.sop = first;
                b.eop = (i == num - 1);
                first = 1'b0;
                exp_q.push_back(b);
            end
        end
        got.delete();
        hs_cyc.delete();
        done_n = 0; done_cyc = 0; tready_bad = 0; tready_seen = 0;
        scl_idx = 0; pnt_idx = 0; scl_on = 1; pnt_on = 1;
        pnt_period = period; rdy_pct = rdy;
        start_cyc = cyc + 1;
        tick(1'b1, num);
        t = 0;
        while (done_n == 0 && t < 500) begin
            tick(stray && (t == 4), 3);
            t++;
        end
        repeat (4) tick(1'b0, num);
        chk({name, ".done_once"}, done_n, 1);
        chk({name, ".beats"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.data%0d", name, i), got[i].d, exp_q[i].d);
            chk($sformatf("%s.sop%0d", name, i), got[i].sop, exp_q[i].sop);
            chk($sformatf("%s.eop%0d", name, i), got[i].eop, exp_q[i].eop);
        end
        exp_done = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] + 1 : start_cyc + 1;
        chk({name, ".done_cyc"}, done_cyc, exp_done);
        chk({name, ".scl_used"}, scl_idx, num);
        chk({name, ".pnt_used"}, pnt_idx, num);
        chk({name, ".tready_pair"}, tready_bad, 0);
        chk({name, ".o_cnt"}, o_cnt, exp_q.size());
        if (num == 0) chk({name, ".no_tready"}, tready_seen, 0);
        if (consec && hs_cyc.size() > 1)
            chk({name, ".consec"}, hs_cyc[hs_cyc.size()-1] - hs_cyc[0], exp_q.size() - 1);
        scl_on = 0; pnt_on = 0;
    endtask

    initial begin
        int t;
        ap_rst_n = 1'b0;
        i_start = 1'b0; i_num_in = '0;
        bus.s_scl_tvalid = 1'b0; bus.s_scl_tdata = '0;
        bus.s_pnt_tvalid = 1'b0; bus.s_pnt_tdata = '0;
        bus.m_tready = 1'b0;
        scl_on = 0; pnt_on = 0; pnt_period = 1; rdy_pct = 100;
        scl_idx = 0; pnt_idx = 0;
        repeat (3) @(negedge ap_clk);
        #1;
        chk("reset.flags", {bus.m_tvalid, bus.m_tsop, bus.m_teop, bus.s_scl_tready,
                            bus.s_pnt_tready, o_busy, o_done}, 7'b0);
        chk("reset.o_cnt", o_cnt, 0);
        ap_rst_n = 1'b1;

        prep(4); run_job("num4", 4, 1, 100, 1'b0, 1'b1);
        prep(1); run_job("num1", 1, 1, 100, 1'b0, 1'b0);
        prep(0); run_job("num0", 0, 1, 100, 1'b0, 1'b0);
        prep(8); run_job("num8", 8, 3, 50, 1'b1, 1'b0);
        t = $urandom_range(2, 12);
        prep(t); run_job("rand", t, $urandom_range(1, 2), 70, 1'b0, 1'b0);

        // Abort a 5-pair job after two pairs have been taken.
        prep(5);
        scl_idx = 0; pnt_idx = 0; scl_on = 1; pnt_on = 1; pnt_period = 1; rdy_pct = 100;
        done_n = 0;
        tick(1'b1, 5);
        t = 0;
        while (scl_idx < 2 && t < 50) begin
            tick(1'b0, 5);
            t++;
        end
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        #1;
        chk("midrst.flags", {bus.m_tvalid, bus.m_tsop, bus.m_teop, bus.s_scl_tready,
                             bus.s_pnt_tready, o_busy, o_done}, 7'b0);
        chk("midrst.o_cnt", o_cnt, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        done_n = 0;
        repeat (4) tick(1'b0, 0);
        chk("midrst.no_done", done_n, 0);
        scl_on = 0; pnt_on = 0;
        prep(2); run_job("rerun2", 2, 1, 100, 1'b0, 1'b0);

        prep(4);
        scl_src[0] = '0; scl_src[1] = SB'(5); scl_src[2] = '0; scl_src[3] = '0;
        run_job("zeros", 4, 1, 100, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/multiexp_g1_input_pair.md
MULTIEXP_G1_INPUT_PAIR -- requirements
Module: multiexp_g1_input_pair

Interface
REQ-001 SHALL have parameter SCL_BITS, default 256, scalar beat width.
REQ-002 SHALL have parameter PNT_BITS, default 512, affine point beat width (x,y).
REQ-003 SHALL have parameter CNT_BITS, default 64, pair-count width.
REQ-004 ap_clk  in  1  single clock; all logic on rising edge.
REQ-005 ap_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_start  in  1  one-cycle start pulse.
REQ-007 i_num_in  in  CNT_BITS  number of scalar/point pairs, sampled on i_start.
REQ-008 s_scl_tvalid / s_scl_tready / s_scl_tdata  in/out/in  1/1/SCL_BITS  scalar stream from the scalar read master.
REQ-009 s_pnt_tvalid / s_pnt_tready / s_pnt_tdata  in/out/in  1/1/PNT_BITS  point stream from the point read master.
REQ-010 m_tvalid / m_tready / m_tdata  out/in/out  1/1/SCL_BITS+PNT_BITS  paired stream to the multiexp core; m_tdata = {point, scalar}, scalar in LSBs.
REQ-011 m_tsop / m_teop  out  1  first / last beat of the job.
REQ-012 o_busy  out  1  high from accepted i_start until o_done.
REQ-013 o_done  out  1  one-cycle pulse at job end.
REQ-014 o_cnt  out  CNT_BITS  pairs emitted on m_* in current/last job.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN.
REQ-016 IDLE: s_scl_tready=s_pnt_tready=0; i_start with i_num_in>0 latches count, clears o_cnt, enters RUN next cycle.
REQ-017 IDLE: i_start with i_num_in==0 SHALL pulse o_done the next cycle, remain IDLE, clear o_cnt.
REQ-018 i_start outside IDLE SHALL be ignored.
REQ-019 RUN: a pair is accepted only when s_scl_tvalid & s_pnt_tvalid & output slot free-or-draining; both treadys assert together, never one alone.
REQ-020 tready MAY depend on tvalid; m_tvalid SHALL NOT depend combinationally on m_tready.
REQ-021 Output is a single registered slot: accepted pair appears on m_* the cycle after acceptance (latency 1); slot held stable while m_tvalid & ~m_tready.
REQ-022 Back-to-back: with m_tready=1 and both inputs valid, one pair per cycle SHALL be sustained.
REQ-023 m_tsop SHALL mark pair index 0; m_teop SHALL mark pair index num-1; num==1 sets both on the same beat.
REQ-024 After the last pair is accepted, treadys SHALL drop to 0 and state enters DRAIN; surplus input beats SHALL NOT be consumed.
REQ-025 DRAIN: when the eop beat handshakes, o_done pulses next cycle and state returns IDLE.
REQ-026 o_cnt SHALL increment on each m_* handshake; counters wrap modulo 2^CNT_BITS.
REQ-027 Mismatched arrival (one stream stalls) SHALL only stall; no beat dropped or duplicated.

Reset
REQ-028 With ap_rst_n=0 at a clock edge: state IDLE; m_tvalid, m_tsop, m_teop, s_*_tready, o_busy, o_done =0; o_cnt=0; m_tdata undefined-but-held; reset mid-job SHALL abandon the job without o_done.

Configuration
REQ-029 Macro MULTIEXP_PAIR_ZERO_SKIP_EN: when defined, accepted pairs with scalar==0 SHALL be consumed but not emitted, except pair index num-1 which is always emitted (carries m_teop); m_tsop marks the first emitted pair; o_cnt counts emitted pairs only.
REQ-030 When not defined, every accepted pair is emitted regardless of scalar value.

Verification
REQ-031 num=4, both streams always valid, m_tready=1 -> 4 beats on consecutive cycles, sop on beat 0, eop on beat 3, o_done one cycle after beat 3, o_cnt=4.
REQ-032 num=1 -> single beat with sop=eop=1, o_done pulse, o_cnt=1.
REQ-033 num=0 start -> no treadys, o_done one cycle later, o_cnt=0.
REQ-034 num=8, point stream valid every 3rd cycle, m_tready random 50% -> 8 beats, data pairs in order, no duplication, 9th offered input beat not consumed.
REQ-035 Reset asserted after 2 of 5 pairs -> all outputs zero next cycle, no o_done; new start num=2 completes normally.
REQ-036 With MULTIEXP_PAIR_ZERO_SKIP_EN, num=4, scalars {0,5,0,0} -> 2 beats (scalar 5 with sop, scalar 0 index 3 with eop), o_cnt=2; without macro -> 4 beats.
